// File: rtl/multicycle_cu_if.sv
// Control-unit bundle: IR/flag/ready inputs toward the control unit and the
// datapath/memory control outputs it drives.
interface multicycle_cu_if #(
    parameter int ALU_OP_W = 3,
    parameter int SEU_OP_W = 2,
    parameter int CNT_W    = 32
);
    logic [10:0]         op_code;
    logic                zero;
    logic                imem_ready;
    logic                dmem_ready;
    logic                imem_req;
    logic                ir_wr;
    logic                pc_wr;
    logic                pc_src;
    logic                reg_to_loc;
    logic [SEU_OP_W-1:0] seu_op;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic                dmem_req;
    logic                mem_wr;
    logic                mem_to_reg;
    logic                reg_wr;
    logic                fault;
    logic [1:0]          fault_cause;
    logic [CNT_W-1:0]    retired;

    modport master (
        input  op_code, zero, imem_ready, dmem_ready,
        output imem_req, ir_wr, pc_wr, pc_src, reg_to_loc, seu_op, alu_src,
               alu_op, dmem_req, mem_wr, mem_to_reg, reg_wr, fault,
               fault_cause, retired
    );

    modport slave (
        output op_code, zero, imem_ready, dmem_ready,
        input  imem_req, ir_wr, pc_wr, pc_src, reg_to_loc, seu_op, alu_src,
               alu_op, dmem_req, mem_wr, mem_to_reg, reg_wr, fault,
               fault_cause, retired
    );
endinterface

// File: rtl/multicycle_cu.sv
// Multi-cycle LEGv8 control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory handshakes, timeout/illegal-opcode fault trapping and a retire counter.
module multicycle_cu #(
    parameter int ALU_OP_W    = 3,
    parameter int SEU_OP_W    = 2,
    parameter int WAIT_W      = 8,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input logic            clk,
    input logic            rst,
    multicycle_cu_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        K_NONE = 3'd0,
        K_B    = 3'd1,
        K_CBZ  = 3'd2,
        K_CBNZ = 3'd3,
        K_ALU  = 3'd4,
        K_STUR = 3'd5,
        K_LDUR = 3'd6
    } kind_t;

    typedef struct packed {
        kind_t               kind;
        logic                reg_to_loc;
        logic [SEU_OP_W-1:0] seu_op;
        logic                alu_src;
        logic [ALU_OP_W-1:0] alu_op;
        logic                mem_to_reg;
    } dec_t;

    localparam bit                TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] TIMEOUT_C  = WAIT_W'(MEM_TIMEOUT);

    function automatic dec_t decode(input logic [10:0] op);
        dec_t d;
        d      = '0;
        d.kind = K_NONE;
        casez (op)
            11'b000101?????: begin
                d.kind   = K_B;
                d.seu_op = SEU_OP_W'(2'b10);
            end
            11'b10110100???, 11'b10110101???: begin
                d.kind       = op[3] ? K_CBNZ : K_CBZ;
                d.reg_to_loc = 1'b1;
                d.seu_op     = SEU_OP_W'(2'b11);
                d.alu_op     = ALU_OP_W'(3'b100);
            end
            11'b1001000100?: begin
                d.kind    = K_ALU;
                d.alu_src = 1'b1;
                d.alu_op  = ALU_OP_W'(3'b000);
            end
            11'b1101000100?: begin
                d.kind    = K_ALU;
                d.alu_src = 1'b1;
                d.alu_op  = ALU_OP_W'(3'b001);
            end
            11'b10001011000: begin
                d.kind   = K_ALU;
                d.alu_op = ALU_OP_W'(3'b000);
            end
            11'b11001011000: begin
                d.kind   = K_ALU;
                d.alu_op = ALU_OP_W'(3'b001);
            end
            11'b10001010000: begin
                d.kind   = K_ALU;
                d.alu_op = ALU_OP_W'(3'b010);
            end
            11'b10101010000: begin
                d.kind   = K_ALU;
                d.alu_op = ALU_OP_W'(3'b011);
            end
            11'b11111000000, 11'b11111000010: begin
                d.kind       = op[1] ? K_LDUR : K_STUR;
                d.reg_to_loc = 1'b1;
                d.seu_op     = SEU_OP_W'(2'b01);
                d.alu_src    = 1'b1;
                d.alu_op     = ALU_OP_W'(3'b000);
                d.mem_to_reg = op[1];
            end
            default: d.kind = K_NONE;
        endcase
        return d;
    endfunction

    state_t            state_q, state_d;
    dec_t              dec_q, dec_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              fault_q, fault_d;
    logic [1:0]        cause_q, cause_d;

    logic imem_req_s, ir_wr_s, pc_wr_s, pc_src_s, dmem_req_s, mem_wr_s, reg_wr_s;

    // State register and all sequential bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            dec_q     <= '0;
            wait_q    <= '0;
            retired_q <= '0;
            fault_q   <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            dec_q     <= dec_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
            cause_q   <= cause_d;
        end
    end

    // Next-state, decode latch, wait counter and retire/fault updates.
    always_comb begin
        state_d   = state_q;
        dec_d     = dec_q;
        wait_d    = '0;
        retired_d = retired_q;
        fault_d   = fault_q;
        cause_d   = cause_q;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ready) begin
                    state_d = S_DECODE;
                end else if (TIMEOUT_EN && (wait_q == TIMEOUT_C)) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    cause_d = 2'b10;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                dec_d = decode(bus.op_code);
                if (dec_d.kind == K_NONE) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    cause_d = 2'b01;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (dec_q.kind)
                    K_B, K_CBZ, K_CBNZ: begin
                        retired_d = retired_q + CNT_W'(1);
                        state_d   = S_FETCH;
                    end
                    K_ALU:          state_d = S_WB;
                    K_STUR, K_LDUR: state_d = S_MEM;
                    default: begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_MEM: begin
                if (bus.dmem_ready) begin
                    if (dec_q.kind == K_STUR) begin
                        retired_d = retired_q + CNT_W'(1);
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (TIMEOUT_EN && (wait_q == TIMEOUT_C)) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    cause_d = 2'b11;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                retired_d = retired_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase
    end

    // Strobe decode; pc_src is only ever driven alongside pc_wr.
    always_comb begin
        imem_req_s = 1'b0;
        ir_wr_s    = 1'b0;
        pc_wr_s    = 1'b0;
        pc_src_s   = 1'b0;
        dmem_req_s = 1'b0;
        mem_wr_s   = 1'b0;
        reg_wr_s   = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_s = 1'b1;
                ir_wr_s    = bus.imem_ready;
            end
            S_EXEC: begin
                case (dec_q.kind)
                    K_B: begin
                        pc_wr_s  = 1'b1;
                        pc_src_s = 1'b1;
                    end
                    K_CBZ: begin
                        pc_wr_s  = 1'b1;
                        pc_src_s = bus.zero;
                    end
                    K_CBNZ: begin
                        pc_wr_s  = 1'b1;
                        pc_src_s = ~bus.zero;
                    end
                    default: pc_wr_s = 1'b0;
                endcase
            end
            S_MEM: begin
                dmem_req_s = 1'b1;
                mem_wr_s   = (dec_q.kind == K_STUR);
                pc_wr_s    = bus.dmem_ready && (dec_q.kind == K_STUR);
            end
            S_WB: begin
                reg_wr_s = 1'b1;
                pc_wr_s  = 1'b1;
            end
            default: imem_req_s = 1'b0;
        endcase
    end

    assign bus.imem_req    = imem_req_s;
    assign bus.ir_wr       = ir_wr_s;
    assign bus.pc_wr       = pc_wr_s;
    assign bus.pc_src      = pc_src_s;
    assign bus.dmem_req    = dmem_req_s;
    assign bus.mem_wr      = mem_wr_s;
    assign bus.reg_wr      = reg_wr_s;
    assign bus.reg_to_loc  = dec_q.reg_to_loc;
    assign bus.seu_op      = dec_q.seu_op;
    assign bus.alu_src     = dec_q.alu_src;
    assign bus.alu_op      = dec_q.alu_op;
    assign bus.mem_to_reg  = dec_q.mem_to_reg;
    assign bus.fault       = fault_q;
    assign bus.fault_cause = cause_q;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for multicycle_cu: a cycle-by-cycle vector table plus a
// retire-counter wrap sequence, with a short timeout and a 4-bit counter.
module tb_multicycle_cu;

    logic clk;
    logic rst;

    multicycle_cu_if #(.ALU_OP_W(3), .SEU_OP_W(2), .CNT_W(4)) bus_if ();

    multicycle_cu #(
        .ALU_OP_W(3), .SEU_OP_W(2), .WAIT_W(8), .MEM_TIMEOUT(4), .CNT_W(4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strobes: {imem_req, ir_wr, pc_wr, pc_src, dmem_req, mem_wr, reg_wr}
    localparam logic [6:0] ST_IDLE = 7'b0000000, ST_FW = 7'b1000000, ST_FR = 7'b1100000,
                           ST_BT   = 7'b0011000, ST_BN = 7'b0010000, ST_WB = 7'b0010001,
                           ST_LD   = 7'b0000100, ST_SW = 7'b0000110, ST_SD = 7'b0010110;
    // fields: {reg_to_loc, seu_op[1:0], alu_src, alu_op[2:0], mem_to_reg}
    localparam logic [7:0] F_0    = 8'b0_00_0_000_0, F_B    = 8'b0_10_0_000_0,
                           F_CB   = 8'b1_11_0_100_0, F_SUBI = 8'b0_00_1_001_0,
                           F_ADDI = 8'b0_00_1_000_0, F_SUB  = 8'b0_00_0_001_0,
                           F_AND  = 8'b0_00_0_010_0, F_ORR  = 8'b0_00_0_011_0,
                           F_ST   = 8'b1_01_1_000_0, F_LD   = 8'b1_01_1_000_1;
    localparam logic [10:0] OP_ADD  = 11'b10001011000, OP_SUB  = 11'b11001011000,
                            OP_AND  = 11'b10001010000, OP_ORR  = 11'b10101010000,
                            OP_ADDI = 11'b10010001000, OP_SUBI = 11'b11010001001,
                            OP_B    = 11'b00010110101, OP_CBZ  = 11'b10110100111,
                            OP_CBNZ = 11'b10110101010, OP_STUR = 11'b11111000000,
                            OP_LDUR = 11'b11111000010, OP_ILL  = 11'b11111111111;

    typedef struct {
        string       tag;
        logic        rst;
        logic [10:0] op;
        logic        zero;
        logic        irdy;
        logic        drdy;
        logic [6:0]  st;
        logic [7:0]  f;
        logic        flt;
        logic [1:0]  cause;
        logic [3:0]  ret;
    } vec_t;

    vec_t vecs[$];
    int   n_pass;
    int   n_total;

    function automatic void vec(input string tag, input logic r, input logic [10:0] op,
                                input logic z, input logic ir, input logic dr,
                                input logic [6:0] st, input logic [7:0] f,
                                input logic fl, input logic [1:0] c, input logic [3:0] rt);
        vec_t v;
        v.tag = tag; v.rst = r; v.op = op; v.zero = z; v.irdy = ir; v.drdy = dr;
        v.st = st; v.f = f; v.flt = fl; v.cause = c; v.ret = rt;
        vecs.push_back(v);
    endfunction

    function automatic logic [6:0] act_st();
        return {bus_if.imem_req, bus_if.ir_wr, bus_if.pc_wr, bus_if.pc_src,
                bus_if.dmem_req, bus_if.mem_wr, bus_if.reg_wr};
    endfunction

    function automatic logic [7:0] act_f();
        return {bus_if.reg_to_loc, bus_if.seu_op, bus_if.alu_src, bus_if.alu_op,
                bus_if.mem_to_reg};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [10:0] lp_op [4];
    logic [7:0]  lp_f  [4];
    logic [3:0]  exp_ret;

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        bus_if.op_code = 11'd0; bus_if.zero = 1'b0;
        bus_if.imem_ready = 1'b0; bus_if.dmem_ready = 1'b0;

        // ADD, SUBI, CBZ z=1, CBNZ z=1, CBNZ z=0, B
        vec("reset_state", 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, ST_FW, F_0, 1'b0, 2'b00, 4'd0);
        vec("add_fetch",   1'b0, OP_ADD, 1'b0, 1'b1, 1'b0, ST_FR, F_0, 1'b0, 2'b00, 4'd0);
        vec("add_decode",  1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, ST_IDLE, F_0, 1'b0, 2'b00, 4'd0);
        vec("add_exec",    1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, ST_IDLE, F_0, 1'b0, 2'b00, 4'd0);
        vec("add_wb",      1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, ST_WB, F_0, 1'b0, 2'b00, 4'd0);
        vec("subi_fetch",  1'b0, OP_SUBI, 1'b0, 1'b1, 1'b0, ST_FR, F_0, 1'b0, 2'b00, 4'd1);
        vec("subi_decode", 1'b0, OP_SUBI, 1'b0, 1'b0, 1'b0, ST_IDLE, F_0, 1'b0, 2'b00, 4'd1);
        vec("subi_exec",   1'b0, OP_SUBI, 1'b0, 1'b0, 1'b0, ST_IDLE, F_SUBI, 1'b0, 2'b00, 4'd1);
        vec("subi_wb",     1'b0, OP_SUBI, 1'b0, 1'b0, 1'b0, ST_WB, F_SUBI, 1'b0, 2'b00, 4'd1);
        vec("cbz_fetch",   1'b0, OP_CBZ, 1'b0, 1'b1, 1'b0, ST_FR, F_SUBI, 1'b0, 2'b00, 4'd2);
        vec("cbz_decode",  1'b0, OP_CBZ, 1'b0, 1'b0, 1'b0, ST_IDLE, F_SUBI, 1'b0, 2'b00, 4'd2);
        vec("cbz_exec_z1", 1'b0, OP_CBZ, 1'b1, 1'b0, 1'b0, ST_BT, F_CB, 1'b0, 2'b00, 4'd2);
        vec("cbnz_fetch",  1'b0, OP_CBNZ, 1'b0, 1'b1, 1'b0, ST_FR, F_CB, 1'b0, 2'b00, 4'd3);
        vec("cbnz_decode", 1'b0, OP_CBNZ, 1'b0, 1'b0, 1'b0, ST_IDLE, F_CB, 1'b0, 2'b00, 4'd3);
        vec("cbnz_exec_z1", 1'b0, OP_CBNZ, 1'b1, 1'b0, 1'b0, ST_BN, F_CB, 1'b0, 2'b00, 4'd3);
        vec("cbnz2_fetch", 1'b0, OP_CBNZ, 1'b0, 1'b1, 1'b0, ST_FR, F_CB, 1'b0, 2'b00, 4'd4);
        vec("cbnz2_decode", 1'b0, OP_CBNZ, 1'b0, 1'b0, 1'b0, ST_IDLE, F_CB, 1'b0, 2'b00, 4'd4);
        vec("cbnz_exec_z0", 1'b0, OP_CBNZ, 1'b0, 1'b0, 1'b0, ST_BT, F_CB, 1'b0, 2'b00, 4'd4);
        vec("b_fetch",     1'b0, OP_B, 1'b0, 1'b1, 1'b0, ST_FR, F_CB, 1'b0, 2'b00, 4'd5);
        vec("b_decode",    1'b0, OP_B, 1'b0, 1'b0, 1'b0, ST_IDLE, F_CB, 1'b0, 2'b00, 4'd5);
        vec("b_exec",      1'b0, OP_B, 1'b0, 1'b0, 1'b0, ST_BT, F_B, 1'b0, 2'b00, 4'd5);
        // LDUR with three dmem wait cycles: 8 cycles total
        vec("ld_fetch",    1'b0, OP_LDUR, 1'b0, 1'b1, 1'b0, ST_FR, F_B, 1'b0, 2'b00, 4'd6);
        vec("ld_decode",   1'b0, OP_LDUR, 1'b0, 1'b0, 1'b0, ST_IDLE, F_B, 1'b0, 2'b00, 4'd6);
        vec("ld_exec",     1'b0, OP_LDUR, 1'b0, 1'b0, 1'b0, ST_IDLE, F_LD, 1'b0, 2'b00, 4'd6);
        for (int i = 0; i < 3; i++)
            vec("ld_mem_wait", 1'b0, OP_LDUR, 1'b0, 1'b0, 1'b0, ST_LD, F_LD, 1'b0, 2'b00, 4'd6);
        vec("ld_mem_rdy",  1'b0, OP_LDUR, 1'b0, 1'b0, 1'b1, ST_LD, F_LD, 1'b0, 2'b00, 4'd6);
        vec("ld_wb",       1'b0, OP_LDUR, 1'b0, 1'b0, 1'b0, ST_WB, F_LD, 1'b0, 2'b00, 4'd6);
        // STUR with dmem ready exactly on the timeout cycle
        vec("st_fetch",    1'b0, OP_STUR, 1'b0, 1'b1, 1'b0, ST_FR, F_LD, 1'b0, 2'b00, 4'd7);
        vec("st_decode",   1'b0, OP_STUR, 1'b0, 1'b0, 1'b0, ST_IDLE, F_LD, 1'b0, 2'b00, 4'd7);
        vec("st_exec",     1'b0, OP_STUR, 1'b0, 1'b0, 1'b0, ST_IDLE, F_ST, 1'b0, 2'b00, 4'd7);
        for (int i = 0; i < 4; i++)
            vec("st_mem_wait", 1'b0, OP_STUR, 1'b0, 1'b0, 1'b0, ST_SW, F_ST, 1'b0, 2'b00, 4'd7);
        vec("st_rdy_at_to", 1'b0, OP_STUR, 1'b0, 1'b0, 1'b1, ST_SD, F_ST, 1'b0, 2'b00, 4'd7);
        // AND with imem ready exactly on the timeout cycle
        for (int i = 0; i < 4; i++)
            vec("and_fetch_wait", 1'b0, OP_AND, 1'b0, 1'b0, 1'b0, ST_FW, F_ST, 1'b0, 2'b00, 4'd8);
        vec("and_rdy_at_to", 1'b0, OP_AND, 1'b0, 1'b1, 1'b0, ST_FR, F_ST, 1'b0, 2'b00, 4'd8);
        vec("and_decode",  1'b0, OP_AND, 1'b0, 1'b0, 1'b0, ST_IDLE, F_ST, 1'b0, 2'b00, 4'd8);
        vec("and_exec",    1'b0, OP_AND, 1'b0, 1'b0, 1'b0, ST_IDLE, F_AND, 1'b0, 2'b00, 4'd8);
        vec("and_wb",      1'b0, OP_AND, 1'b0, 1'b0, 1'b0, ST_WB, F_AND, 1'b0, 2'b00, 4'd8);
        // reset in the middle of an LDUR dmem wait
        vec("rm_fetch",    1'b0, OP_LDUR, 1'b0, 1'b1, 1'b0, ST_FR, F_AND, 1'b0, 2'b00, 4'd9);
        vec("rm_decode",   1'b0, OP_LDUR, 1'b0, 1'b0, 1'b0, ST_IDLE, F_AND, 1'b0, 2'b00, 4'd9);
        vec("rm_exec",     1'b0, OP_LDUR, 1'b0, 1'b0, 1'b0, ST_IDLE, F_LD, 1'b0, 2'b00, 4'd9);
        vec("rm_mem_wait", 1'b0, OP_LDUR, 1'b0, 1'b0, 1'b0, ST_LD, F_LD, 1'b0, 2'b00, 4'd9);
        vec("rm_rst",      1'b1, OP_LDUR, 1'b0, 1'b0, 1'b0, ST_LD, F_LD, 1'b0, 2'b00, 4'd9);
        vec("rm_after_rst", 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, ST_FW, F_0, 1'b0, 2'b00, 4'd0);
        vec("add2_fetch",  1'b0, OP_ADD, 1'b0, 1'b1, 1'b0, ST_FR, F_0, 1'b0, 2'b00, 4'd0);
        vec("add2_decode", 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, ST_IDLE, F_0, 1'b0, 2'b00, 4'd0);
        vec("add2_exec",   1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, ST_IDLE, F_0, 1'b0, 2'b00, 4'd0);
        vec("add2_wb",     1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, ST_WB, F_0, 1'b0, 2'b00, 4'd0);
        // illegal opcode traps from DECODE; ready inputs ignored in FAULT
        vec("ill_fetch",   1'b0, OP_ILL, 1'b0, 1'b1, 1'b0, ST_FR, F_0, 1'b0, 2'b00, 4'd1);
        vec("ill_decode",  1'b0, OP_ILL, 1'b0, 1'b0, 1'b0, ST_IDLE, F_0, 1'b0, 2'b00, 4'd1);
        vec("ill_fault",   1'b0, OP_ILL, 1'b1, 1'b1, 1'b1, ST_IDLE, F_0, 1'b1, 2'b01, 4'd1);
        vec("ill_sticky",  1'b0, OP_ILL, 1'b0, 1'b1, 1'b1, ST_IDLE, F_0, 1'b1, 2'b01, 4'd1);
        vec("ill_rst",     1'b1, OP_ILL, 1'b0, 1'b0, 1'b0, ST_IDLE, F_0, 1'b1, 2'b01, 4'd1);
        // imem timeout after the 5th FETCH cycle
        for (int i = 0; i < 5; i++)
            vec("ito_fetch",  1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, ST_FW, F_0, 1'b0, 2'b00, 4'd0);
        vec("ito_fault",   1'b0, OP_ADD, 1'b0, 1'b1, 1'b0, ST_IDLE, F_0, 1'b1, 2'b10, 4'd0);
        vec("ito_sticky",  1'b0, OP_ADD, 1'b0, 1'b1, 1'b1, ST_IDLE, F_0, 1'b1, 2'b10, 4'd0);
        vec("ito_rst",     1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, ST_IDLE, F_0, 1'b1, 2'b10, 4'd0);
        // dmem timeout on STUR
        vec("dto_fetch",   1'b0, OP_STUR, 1'b0, 1'b1, 1'b0, ST_FR, F_0, 1'b0, 2'b00, 4'd0);
        vec("dto_decode",  1'b0, OP_STUR, 1'b0, 1'b0, 1'b0, ST_IDLE, F_0, 1'b0, 2'b00, 4'd0);
        vec("dto_exec",    1'b0, OP_STUR, 1'b0, 1'b0, 1'b0, ST_IDLE, F_ST, 1'b0, 2'b00, 4'd0);
        for (int i = 0; i < 5; i++)
            vec("dto_mem_wait", 1'b0, OP_STUR, 1'b0, 1'b0, 1'b0, ST_SW, F_ST, 1'b0, 2'b00, 4'd0);
        vec("dto_fault",   1'b0, OP_STUR, 1'b0, 1'b0, 1'b1, ST_IDLE, F_ST, 1'b1, 2'b11, 4'd0);
        vec("dto_rst",     1'b1, OP_STUR, 1'b0, 1'b0, 1'b0, ST_IDLE, F_ST, 1'b1, 2'b11, 4'd0);

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst               = vecs[i].rst;
            bus_if.op_code    = vecs[i].op;
            bus_if.zero       = vecs[i].zero;
            bus_if.imem_ready = vecs[i].irdy;
            bus_if.dmem_ready = vecs[i].drdy;
            #1;
            chk($sformatf("v%0d_%s", i, vecs[i].tag),
                {10'd0, act_st(), act_f(), bus_if.fault, bus_if.fault_cause, bus_if.retired},
                {10'd0, vecs[i].st, vecs[i].f, vecs[i].flt, vecs[i].cause, vecs[i].ret});
            tick();
        end

        // 16 R/I instructions with a 4-bit counter: retired wraps back to 0
        lp_op[0] = OP_ADD;  lp_f[0] = F_0;
        lp_op[1] = OP_ADDI; lp_f[1] = F_ADDI;
        lp_op[2] = OP_SUB;  lp_f[2] = F_SUB;
        lp_op[3] = OP_ORR;  lp_f[3] = F_ORR;
        exp_ret = 4'd0;
        rst = 1'b0;
        bus_if.zero = 1'b0;
        bus_if.dmem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus_if.op_code    = lp_op[i % 4];
            bus_if.imem_ready = 1'b1;
            #1;
            chk($sformatf("wrap%0d_fetch", i), {25'd0, act_st()}, {25'd0, ST_FR});
            chk($sformatf("wrap%0d_retired", i), {28'd0, bus_if.retired}, {28'd0, exp_ret});
            tick();
            bus_if.imem_ready = 1'b0;
            tick();
            chk($sformatf("wrap%0d_exec_fields", i), {24'd0, act_f()}, {24'd0, lp_f[i % 4]});
            tick();
            chk($sformatf("wrap%0d_wb", i), {25'd0, act_st()}, {25'd0, ST_WB});
            tick();
            exp_ret = exp_ret + 4'd1;
        end
        chk("wrap_final_retired", {28'd0, bus_if.retired}, {28'd0, exp_ret});
        chk("wrap_final_fault", {31'd0, bus_if.fault}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
